// File: rtl/axis_frame_trunc.sv
// AXI stream frame length limiter: forwards frames up to a runtime byte limit,
// cuts longer frames at the limit (tlast + bad tuser) and reports per-frame status.
`timescale 1ns/1ps

module axis_frame_trunc #(
  parameter int DATA_WIDTH  = 64,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit ID_ENABLE   = 1,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 1,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  input  logic [LEN_WIDTH-1:0]  length_max,
  output logic                  status_valid,
  output logic [LEN_WIDTH-1:0]  status_frame_len,
  output logic                  status_truncated
);

  localparam int CNT_W = LEN_WIDTH + 1;

  typedef enum logic [0:0] {
    TRANSFER = 1'b0,
    DROP     = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [LEN_WIDTH-1:0]  cnt_reg;
  logic [LEN_WIDTH-1:0]  lim_reg;
  logic                  frame_active_reg;
  logic                  trunc_reg;
  logic                  s_ready_reg;

  logic [DATA_WIDTH-1:0] m_data_reg,  temp_data_reg;
  logic [KEEP_WIDTH-1:0] m_keep_reg,  temp_keep_reg;
  logic                  m_last_reg,  temp_last_reg;
  logic [ID_WIDTH-1:0]   m_id_reg,    temp_id_reg;
  logic [DEST_WIDTH-1:0] m_dest_reg,  temp_dest_reg;
  logic [USER_WIDTH-1:0] m_user_reg,  temp_user_reg;
  logic                  m_valid_reg, temp_valid_reg;
  logic                  m_valid_next, temp_valid_next;
  logic                  in_to_out, in_to_temp, temp_to_out;

  logic                  status_valid_reg;
  logic [LEN_WIDTH-1:0]  status_len_reg;
  logic                  status_trunc_reg;

  logic [KEEP_WIDTH-1:0] in_keep;
  logic [CNT_W-1:0]      beat_bytes;
  logic [LEN_WIDTH-1:0]  cur_lim;
  logic [CNT_W-1:0]      total;
  logic [LEN_WIDTH-1:0]  total_sat;
  logic [LEN_WIDTH-1:0]  remain;
  logic [KEEP_WIDTH-1:0] keep_mask;
  logic                  accept;
  logic                  fwd;
  logic                  cut;

  logic [KEEP_WIDTH-1:0] fwd_keep;
  logic                  fwd_last;
  logic [USER_WIDTH-1:0] fwd_user;

  function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      c = c + CNT_W'(keep[i]);
    end
    return c;
  endfunction

  // Byte accounting and the truncation decision for the beat on the input.
  always_comb begin
    in_keep    = KEEP_ENABLE ? s_axis_tkeep : '1;
    beat_bytes = KEEP_ENABLE ? popcount(s_axis_tkeep) : CNT_W'(KEEP_WIDTH);
    cur_lim    = frame_active_reg ? lim_reg : length_max;
    total      = {1'b0, cnt_reg} + beat_bytes;
    total_sat  = total[LEN_WIDTH] ? '1 : total[LEN_WIDTH-1:0];
    remain     = cur_lim - cnt_reg;
    keep_mask  = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_mask[i] = (remain > LEN_WIDTH'(i));
    end

    accept = s_axis_tvalid && s_ready_reg;
    fwd    = accept && (state_reg == TRANSFER);
    cut    = 1'b0;
    if (fwd && (cur_lim != '0)) begin
      if (s_axis_tlast) begin
        cut = (total > {1'b0, cur_lim});
      end else begin
        cut = (total >= {1'b0, cur_lim});
      end
    end

    fwd_keep    = cut ? (in_keep & keep_mask) : in_keep;
    fwd_last    = s_axis_tlast | cut;
    fwd_user    = s_axis_tuser;
    fwd_user[0] = s_axis_tuser[0] | cut;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TRANSFER: if (cut && !s_axis_tlast) state_next = DROP;
      DROP:     if (accept && s_axis_tlast) state_next = TRANSFER;
      default:  state_next = TRANSFER;
    endcase
  end

  // Two-entry output skid: the output register plus one overflow slot.
  always_comb begin
    m_valid_next    = m_valid_reg;
    temp_valid_next = temp_valid_reg;
    in_to_out       = 1'b0;
    in_to_temp      = 1'b0;
    temp_to_out     = 1'b0;
    if (m_axis_tready || !m_valid_reg) begin
      if (temp_valid_reg) begin
        m_valid_next    = 1'b1;
        temp_to_out     = 1'b1;
        temp_valid_next = fwd;
        in_to_temp      = fwd;
      end else begin
        m_valid_next = fwd;
        in_to_out    = fwd;
      end
    end else if (fwd) begin
      temp_valid_next = 1'b1;
      in_to_temp      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= TRANSFER;
      s_ready_reg      <= 1'b0;
      m_valid_reg      <= 1'b0;
      temp_valid_reg   <= 1'b0;
      cnt_reg          <= '0;
      lim_reg          <= '0;
      frame_active_reg <= 1'b0;
      trunc_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      s_ready_reg    <= (state_next == DROP) || !temp_valid_next;
      m_valid_reg    <= m_valid_next;
      temp_valid_reg <= temp_valid_next;
      if (accept) begin
        if (s_axis_tlast) begin
          cnt_reg          <= '0;
          frame_active_reg <= 1'b0;
          trunc_reg        <= 1'b0;
        end else begin
          cnt_reg          <= total_sat;
          frame_active_reg <= 1'b1;
          if (!frame_active_reg) lim_reg <= length_max;
          if (cut) trunc_reg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data_reg    <= '0;
      m_keep_reg    <= '0;
      m_last_reg    <= 1'b0;
      m_id_reg      <= '0;
      m_dest_reg    <= '0;
      m_user_reg    <= '0;
      temp_data_reg <= '0;
      temp_keep_reg <= '0;
      temp_last_reg <= 1'b0;
      temp_id_reg   <= '0;
      temp_dest_reg <= '0;
      temp_user_reg <= '0;
    end else begin
      if (in_to_out) begin
        m_data_reg <= s_axis_tdata;
        m_keep_reg <= fwd_keep;
        m_last_reg <= fwd_last;
        m_id_reg   <= s_axis_tid;
        m_dest_reg <= s_axis_tdest;
        m_user_reg <= fwd_user;
      end else if (temp_to_out) begin
        m_data_reg <= temp_data_reg;
        m_keep_reg <= temp_keep_reg;
        m_last_reg <= temp_last_reg;
        m_id_reg   <= temp_id_reg;
        m_dest_reg <= temp_dest_reg;
        m_user_reg <= temp_user_reg;
      end
      if (in_to_temp) begin
        temp_data_reg <= s_axis_tdata;
        temp_keep_reg <= fwd_keep;
        temp_last_reg <= fwd_last;
        temp_id_reg   <= s_axis_tid;
        temp_dest_reg <= s_axis_tdest;
        temp_user_reg <= fwd_user;
      end
    end
  end

  // Status reports the whole input frame, including bytes discarded in DROP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_valid_reg <= 1'b0;
      status_len_reg   <= '0;
      status_trunc_reg <= 1'b0;
    end else begin
      status_valid_reg <= accept && s_axis_tlast;
      if (accept && s_axis_tlast) begin
        status_len_reg   <= total_sat;
        status_trunc_reg <= trunc_reg | cut;
      end
    end
  end

  assign s_axis_tready    = s_ready_reg;
  assign m_axis_tvalid    = m_valid_reg;
  assign m_axis_tdata     = m_data_reg;
  assign m_axis_tkeep     = m_keep_reg;
  assign m_axis_tlast     = m_last_reg;
  assign m_axis_tid       = ID_ENABLE   ? m_id_reg   : '0;
  assign m_axis_tdest     = DEST_ENABLE ? m_dest_reg : '0;
  assign m_axis_tuser     = USER_ENABLE ? m_user_reg : '0;
  assign status_valid     = status_valid_reg;
  assign status_frame_len = status_len_reg;
  assign status_truncated = status_trunc_reg;

endmodule

// File: tb/tb_axis_frame_trunc.sv
// Scoreboard bench for axis_frame_trunc: a behavioural model queues expected
// output beats and status words as input beats are accepted.
`timescale 1ns/1ps

module tb_axis_frame_trunc;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic        user;
  } beat_t;

  typedef struct packed {
    logic [15:0] len;
    logic        trunc;
  } status_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  s_axis_tid = '0;
  logic [7:0]  s_axis_tdest = '0;
  logic [0:0]  s_axis_tuser = '0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tid;
  logic [7:0]  m_axis_tdest;
  logic [0:0]  m_axis_tuser;
  logic [15:0] length_max = '0;
  logic        status_valid;
  logic [15:0] status_frame_len;
  logic        status_truncated;

  axis_frame_trunc dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tid       (s_axis_tid),
    .s_axis_tdest     (s_axis_tdest),
    .s_axis_tuser     (s_axis_tuser),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tid       (m_axis_tid),
    .m_axis_tdest     (m_axis_tdest),
    .m_axis_tuser     (m_axis_tuser),
    .length_max       (length_max),
    .status_valid     (status_valid),
    .status_frame_len (status_frame_len),
    .status_truncated (status_truncated)
  );

  always #5 clk = ~clk;

  beat_t   exp_q[$];
  status_t stat_q[$];
  int      checks_total  = 0;
  int      checks_passed = 0;
  bit      rand_ready    = 1'b0;
  int      frame_id      = 0;

  int m_cnt    = 0;
  int m_lim    = 0;
  bit m_active = 1'b0;
  bit m_drop   = 1'b0;
  bit m_trunc  = 1'b0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_cnt = 0; m_lim = 0; m_active = 1'b0; m_drop = 1'b0; m_trunc = 1'b0;
  endtask

  // Reference behaviour for one accepted input beat.
  task automatic modelAccept(input beat_t b);
    int      n;
    int      total;
    beat_t   e;
    status_t s;
    n = $countones(b.keep);
    if (!m_active) m_lim = int'(length_max);
    total = m_cnt + n;
    if (!m_drop) begin
      e = b;
      if (m_lim != 0 && (b.last ? (total > m_lim) : (total >= m_lim))) begin
        e.keep  = b.keep & 8'((1 << (m_lim - m_cnt)) - 1);
        e.last  = 1'b1;
        e.user  = 1'b1;
        m_trunc = 1'b1;
        if (!b.last) m_drop = 1'b1;
      end
      exp_q.push_back(e);
    end
    m_cnt = (total > 65535) ? 65535 : total;
    if (b.last) begin
      s.len   = 16'(m_cnt);
      s.trunc = m_trunc;
      stat_q.push_back(s);
      modelReset();
    end else begin
      m_active = 1'b1;
    end
  endtask

  // Drive one beat; caller must be just after a rising edge. Returns just after
  // the rising edge on which the beat was accepted.
  task automatic applyStimulus(input logic [63:0] data, input logic [7:0] keep, input logic last,
                               input logic [7:0] id, input logic [7:0] dest, input logic user);
    bit    rdy;
    int    waited;
    beat_t b;
    s_axis_tdata  = data;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tid    = id;
    s_axis_tdest  = dest;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    rdy    = 1'b0;
    waited = 0;
    while (!rdy && waited < 200) begin
      @(negedge clk);
      rdy = s_axis_tready;
      @(posedge clk);
      waited++;
    end
    checkOutput("s_tready_wait", 128'(rdy), 128'(1));
    if (rdy) begin
      b = '{data: data, keep: keep, last: last, id: id, dest: dest, user: user};
      modelAccept(b);
    end
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic sendFrame(input int nbytes, input int new_lim, input logic user);
    int rem;
    int b;
    bit first;
    rem   = nbytes;
    first = 1'b1;
    while (rem > 0) begin
      b   = (rem > 8) ? 8 : rem;
      rem = rem - b;
      applyStimulus({$urandom(), $urandom()}, 8'((1 << b) - 1), rem == 0,
                    8'(frame_id), 8'(~frame_id), user);
      if (first && new_lim >= 0) length_max = 16'(new_lim);
      first = 1'b0;
    end
    frame_id++;
  endtask

  task automatic alignTx();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0 || m_axis_tvalid) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("drain_beats", 128'(exp_q.size()), 128'(0));
    checkOutput("drain_status", 128'(stat_q.size()), 128'(0));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_m_tvalid"}, 128'(m_axis_tvalid), 128'(0));
    checkOutput({tag, "_s_tready"}, 128'(s_axis_tready), 128'(0));
    checkOutput({tag, "_status_valid"}, 128'(status_valid), 128'(0));
    checkOutput({tag, "_status_trunc"}, 128'(status_truncated), 128'(0));
    checkOutput({tag, "_status_len"}, 128'(status_frame_len), 128'(0));
    checkOutput({tag, "_m_beat"},
                128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser}),
                128'(0));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare on handshakes, hold check while stalled.
  beat_t cur_beat;
  beat_t stall_beat;
  bit    stall_prev = 1'b0;
  beat_t exp_beat;
  status_t exp_stat;

  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      cur_beat = '{data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast,
                   id: m_axis_tid, dest: m_axis_tdest, user: m_axis_tuser};
      if (stall_prev) begin
        checkOutput("hold_valid", 128'(m_axis_tvalid), 128'(1));
        checkOutput("hold_beat", 128'(cur_beat), 128'(stall_beat));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checkOutput("beat_expected", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) begin
          exp_beat = exp_q.pop_front();
          checkOutput("out_beat", 128'(cur_beat), 128'(exp_beat));
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_beat = cur_beat;
      if (status_valid) begin
        checkOutput("status_expected", 128'(stat_q.size() > 0), 128'(1));
        if (stat_q.size() > 0) begin
          exp_stat = stat_q.pop_front();
          checkOutput("status", 128'({status_frame_len, status_truncated}), 128'(exp_stat));
        end
      end
    end
  end

  int lens [12] = '{40, 41, 3, 70, 8, 39, 16, 1, 55, 24, 33, 48};

  initial begin
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("s_tready_after_reset", 128'(s_axis_tready), 128'(1));
    alignTx();

    $display("[TB] no limit, 20-byte frame");
    length_max = 16'd0;
    sendFrame(20, -1, 1'b0);
    $display("[TB] limit 16, 20-byte frame");
    length_max = 16'd16;
    sendFrame(20, -1, 1'b0);
    $display("[TB] limit 12, 24-byte frame");
    length_max = 16'd12;
    sendFrame(24, -1, 1'b0);
    $display("[TB] limit 16, 16- and 17-byte frames");
    length_max = 16'd16;
    sendFrame(16, -1, 1'b0);
    sendFrame(17, -1, 1'b0);
    $display("[TB] limit change mid-frame is ignored");
    length_max = 16'd16;
    sendFrame(24, 0, 1'b0);
    sendFrame(24, -1, 1'b1);
    waitDrain();
    alignTx();

    $display("[TB] random m_axis_tready, limit 40, back-to-back frames");
    rand_ready = 1'b1;
    length_max = 16'd40;
    foreach (lens[i]) sendFrame(lens[i], -1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) sendFrame($urandom_range(1, 80), -1, 1'b0);
    waitDrain();
    rand_ready = 1'b0;
    alignTx();

    $display("[TB] reset while dropping");
    length_max = 16'd8;
    applyStimulus(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 8'h55, 8'h66, 1'b0);
    applyStimulus(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 8'h55, 8'h66, 1'b0);
    applyStimulus(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b0, 8'h55, 8'h66, 1'b0);
    waitDrain();
    rst = 1'b0;
    #1;
    checkResetValues("midreset");
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    alignTx();
    length_max = 16'd16;
    sendFrame(16, -1, 1'b0);
    sendFrame(20, -1, 1'b0);
    waitDrain();

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
